// File: rtl/mux_pipe_reg_if.sv
// Bundle for the select/skid stage: K-channel input bus, registered output bus and the handshakes.
// The slave modport is the stage itself; the master modport is whoever drives and consumes it.
// All signals are plain wires; timing belongs to the attached stage.
interface mux_pipe_reg_if #(
  parameter int N    = 32,
  parameter int K    = 4,
  parameter int SELW = 2
);
  logic [K*N-1:0]  in_data;
  logic [SELW-1:0] sel;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [N-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_valid;
  logic            out_ready;
  logic            sel_err;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/mux_pipe_reg.sv
// K-way N-bit operand select feeding a 2-entry skid buffer, with flush and sticky illegal-select flag.
// Latency: 1 cycle from accept to out_* when empty or streaming through.
// Backpressure: in_ready depends only on occupancy (no combinational path from out_ready).
module mux_pipe_reg #(
  parameter int N    = 32,
  parameter int K    = 4,
  parameter int SELW = 2
) (
  input  logic           clk,
  input  logic           rst,
  mux_pipe_reg_if.slave  bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // One extra bit so K == 2**SELW is representable for the range check.
  localparam logic [SELW:0] K_W = (SELW+1)'(K);

  logic [1:0]      count;
  logic [N-1:0]    head_data;
  logic [SELW-1:0] head_sel;
  logic [N-1:0]    tail_data;
  logic [SELW-1:0] tail_sel;
  logic            sel_err_q;

  logic [N-1:0]    mux_data;
  logic            sel_bad;
  logic            push;
  logic            pop;

  assign sel_bad = ({1'b0, bus.sel} >= K_W);

  // Pick the selected channel; an out-of-range select yields zero data.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < K; i++) begin
      if (bus.sel == SELW'(i)) begin
        mux_data = bus.in_data[i*N +: N];
      end
    end
  end

  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Head is zeroed while empty so stale entries never leak out.
  assign bus.out_data  = bus.out_valid ? head_data : '0;
  assign bus.out_sel   = bus.out_valid ? head_sel  : '0;
  assign bus.sel_err   = sel_err_q;

  // Occupancy and entry storage; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= EMPTY;
      head_data <= '0;
      head_sel  <= '0;
      tail_data <= '0;
      tail_sel  <= '0;
    end else if (bus.flush) begin
      count <= EMPTY;
    end else begin
      case (count)
        EMPTY: begin
          if (push) begin
            head_data <= mux_data;
            head_sel  <= bus.sel;
            count     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_data <= mux_data;
            head_sel  <= bus.sel;
          end else if (push) begin
            tail_data <= mux_data;
            tail_sel  <= bus.sel;
            count     <= FULL;
          end else if (pop) begin
            count <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_data <= tail_data;
            head_sel  <= tail_sel;
            count     <= ONE;
          end
        end
        default: count <= EMPTY;
      endcase
    end
  end

  // Sticky illegal-select flag; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (push && sel_bad && !bus.flush) begin
      sel_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg: a K=4 instance for the main flow and a K=3 instance
// for illegal-select handling; inputs change 1 time unit after the rising edge and
// outputs are checked at the same point, away from the active edge.
module tb_mux_pipe_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux_pipe_reg_if #(.N(32), .K(4), .SELW(2)) bus0 ();
  mux_pipe_reg_if #(.N(32), .K(3), .SELW(2)) bus1 ();

  mux_pipe_reg #(.N(32), .K(4), .SELW(2)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_pipe_reg #(.N(32), .K(3), .SELW(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [31:0] chv [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chv[0] = 32'h1234_0000;
    chv[1] = 32'hBEEF_0001;
    chv[2] = 32'hCAFE_0002;
    chv[3] = 32'hDEAD_0003;

    rst = 1'b1;
    bus0.in_data = {chv[3], chv[2], chv[1], chv[0]};
    bus0.sel = 2'd0; bus0.in_valid = 1'b0; bus0.flush = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_data = '0;
    bus1.sel = 2'd0; bus1.in_valid = 1'b0; bus1.flush = 1'b0; bus1.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus0.out_data), 64'd0);
    chk("rst_out_sel", 64'(bus0.out_sel), 64'd0);
    chk("rst_sel_err", 64'(bus0.sel_err), 64'd0);
    #9;
    rst = 1'b0;
    tick();

    // 1: single transfer, one-cycle latency
    bus0.sel = 2'd2; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    chk("t1_valid", 64'(bus0.out_valid), 64'd1);
    chk("t1_data", 64'(bus0.out_data), 64'hCAFE_0002);
    chk("t1_sel", 64'(bus0.out_sel), 64'd2);
    tick();
    chk("t1_drain_valid", 64'(bus0.out_valid), 64'd0);
    chk("t1_drain_data", 64'(bus0.out_data), 64'd0);

    // 2: backpressure, A/B fill, C held upstream, then drain in order
    bus0.out_ready = 1'b0;
    bus0.sel = 2'd0; bus0.in_valid = 1'b1;
    tick();
    chk("t2_a_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("t2_a_head", 64'(bus0.out_data), 64'(chv[0]));
    bus0.sel = 2'd1;
    tick();
    chk("t2_full_in_ready", 64'(bus0.in_ready), 64'd0);
    chk("t2_full_head", 64'(bus0.out_data), 64'(chv[0]));
    bus0.sel = 2'd3;
    tick();
    chk("t2_hold_in_ready", 64'(bus0.in_ready), 64'd0);
    chk("t2_hold_head", 64'(bus0.out_data), 64'(chv[0]));
    chk("t2_hold_sel", 64'(bus0.out_sel), 64'd0);
    bus0.out_ready = 1'b1;
    tick();
    chk("t2_b_valid", 64'(bus0.out_valid), 64'd1);
    chk("t2_b_data", 64'(bus0.out_data), 64'(chv[1]));
    chk("t2_b_in_ready", 64'(bus0.in_ready), 64'd1);
    tick();
    bus0.in_valid = 1'b0;
    chk("t2_c_valid", 64'(bus0.out_valid), 64'd1);
    chk("t2_c_data", 64'(bus0.out_data), 64'(chv[3]));
    chk("t2_c_sel", 64'(bus0.out_sel), 64'd3);
    tick();
    chk("t2_empty", 64'(bus0.out_valid), 64'd0);

    // 3: streaming, one output per cycle, never fills
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus0.sel = 2'(i % 4);
      tick();
      chk("t3_valid", 64'(bus0.out_valid), 64'd1);
      chk("t3_data", 64'(bus0.out_data), 64'(chv[i % 4]));
      chk("t3_in_ready", 64'(bus0.in_ready), 64'd1);
    end
    bus0.in_valid = 1'b0;
    tick();
    chk("t3_empty", 64'(bus0.out_valid), 64'd0);

    // 4: flush while full, same-cycle push dropped
    bus0.out_ready = 1'b0; bus0.in_valid = 1'b1; bus0.sel = 2'd0;
    tick();
    bus0.sel = 2'd1;
    tick();
    chk("t4_full", 64'(bus0.in_ready), 64'd0);
    bus0.flush = 1'b1; bus0.sel = 2'd2;
    tick();
    bus0.flush = 1'b0; bus0.in_valid = 1'b0;
    chk("t4_flush_valid", 64'(bus0.out_valid), 64'd0);
    chk("t4_flush_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("t4_flush_data", 64'(bus0.out_data), 64'd0);
    bus0.out_ready = 1'b1;
    tick();
    chk("t4_nothing_after", 64'(bus0.out_valid), 64'd0);

    // 5: illegal select on K=3 instance
    bus1.in_data = {96{1'b1}};
    bus1.sel = 2'd3; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
    tick();
    chk("t5_valid", 64'(bus1.out_valid), 64'd1);
    chk("t5_data", 64'(bus1.out_data), 64'd0);
    chk("t5_sel", 64'(bus1.out_sel), 64'd3);
    chk("t5_err", 64'(bus1.sel_err), 64'd1);
    bus1.sel = 2'd1;
    tick();
    bus1.in_valid = 1'b0;
    chk("t5_legal_data", 64'(bus1.out_data), 64'hFFFF_FFFF);
    chk("t5_err_after_push", 64'(bus1.sel_err), 64'd1);
    bus1.flush = 1'b1;
    tick();
    bus1.flush = 1'b0;
    chk("t5_err_after_flush", 64'(bus1.sel_err), 64'd1);
    chk("t5_other_inst_err", 64'(bus0.sel_err), 64'd0);

    // 6: async reset mid-cycle while full
    bus0.out_ready = 1'b0; bus0.in_valid = 1'b1; bus0.sel = 2'd2;
    tick();
    bus0.sel = 2'd3;
    tick();
    bus0.in_valid = 1'b0;
    chk("t6_full", 64'(bus0.in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(bus0.out_valid), 64'd0);
    chk("t6_async_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("t6_async_data", 64'(bus0.out_data), 64'd0);
    chk("t6_async_err", 64'(bus1.sel_err), 64'd0);
    #4;
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    chk("t6_post_valid", 64'(bus0.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
